// File: rtl/uart_pkg.sv
// Shared UART definitions for the RX and TX sides.
// Holds the frame state encoding and the default serial parameters.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 16;
    localparam int unsigned UART_DATA_BITS    = 8;
    localparam int unsigned UART_SYNC_STAGES  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte stream: valid/ready handshake from the receiver to its consumer.
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] rx_dat;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_dat, output rx_valid, input rx_ready);
    modport slave  (input rx_dat, input rx_valid, output rx_ready);

endinterface

// File: rtl/uart_sync.sv
// N-stage bit synchronizer for the asynchronous serial line; flops reset to idle-high.
module uart_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (reset) begin
            ff <= '1;
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of rxd, LSB-first byte assembly, valid/ready delivery
// with single-cycle framing-error and overrun flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS,
    parameter int unsigned SYNC_STAGES  = UART_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    uart_rx_if.master  rx,
    output logic       is_rcv,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    logic                 rxd_s;
    uart_state_e          state;
    logic [CW-1:0]        bit_cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shift;
    logic                 deliver;

    uart_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rxd),
        .q     (rxd_s)
    );

    // Frame FSM; shift fills from the top so the first (LSB) bit ends in bit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            idx       <= '0;
            shift     <= '0;
            is_rcv    <= 1'b0;
            frame_err <= 1'b0;
            deliver   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            deliver   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state   <= ST_START;
                        bit_cnt <= '0;
                        is_rcv  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        idx     <= '0;
                        if (rxd_s) begin
                            state  <= ST_IDLE;
                            is_rcv <= 1'b0;
                        end else begin
                            state <= ST_DATA;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        shift   <= {rxd_s, shift[DATA_BITS-1:1]};
                        if (idx == IDX_LAST) begin
                            idx   <= '0;
                            state <= ST_STOP;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        is_rcv  <= 1'b0;
                        if (rxd_s) begin
                            deliver <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_BREAK;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                ST_BREAK: begin
                    if (rxd_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output holding register: a new byte replaces the old only if the old one leaves now.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx.rx_dat   <= '0;
            rx.rx_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (deliver) begin
                if (!rx.rx_valid || rx.rx_ready) begin
                    rx.rx_dat   <= shift;
                    rx.rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx.rx_valid && rx.rx_ready) begin
                rx.rx_valid <= 1'b0;
            end
        end
    end

endmodule
